multicycle_control: RTL
=======================

# multicycle_control

Multicycle main control unit for the MIPS datapath. It decodes the 6-bit instruction opcode and steps through fetch, decode, execute, memory and writeback states. Each cycle it drives the datapath strobes and the 2-bit `ALU_op` class code, which the downstream ALU control decoder combines with the funct field. It is the producer side of the `ALU_op` interface.

## Interface
- No parameters; all encodings are fixed below.
- `clk` in 1 — single clock, rising edge.
- `reset` in 1 — synchronous, active-high.
- `opcode` in 6 — instruction[31:26]; only sampled in DECODE, from the instruction register.
- `mem_ready` in 1 — memory handshake; high when the current read/write completes this cycle.
- `ALU_op` out 2 — 00 add (address / PC+4), 01 subtract (compare), 10 use funct.
- `alu_src_a` out 1 — 0 = PC, 1 = register A.
- `alu_src_b` out 2 — 00 register B, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm<<2.
- `pc_source` out 2 — 00 ALU result, 01 ALUOut register, 10 jump target.
- `pc_write`, `pc_write_cond`, `pc_write_cond_n` out 1 each — unconditional PC write, PC write on zero (beq), PC write on not-zero (bne).
- `i_or_d` out 1 — memory address select: 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write`, `ir_write` out 1 each.
- `reg_write` out 1; `reg_dst` out 1 (0 = rt, 1 = rd); `mem_to_reg` out 1 (0 = ALUOut, 1 = MDR).
- `illegal_op` out 1 — one-cycle pulse on an unsupported opcode.
- `state` out 4 — current state encoding, for debug/verification.

## Operation
- States and encodings:
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5
  - R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11
  - Codes 12–15 are unused and recover to FETCH on the next edge.
- Outputs are decoded from `state`. The only exceptions are the `mem_ready`-qualified strobes noted below. Any output not listed for a state is 0.
- FETCH:
  - `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `ALU_op`=00, `pc_source`=00.
  - `ir_write` = `pc_write` = `mem_ready`.
  - Stays in FETCH while `mem_ready`=0; goes to DECODE when `mem_ready`=1.
- DECODE:
  - `alu_src_a`=0, `alu_src_b`=11, `ALU_op`=00 (branch target into ALUOut).
  - Next state by opcode:
    - 100011 lw / 101011 sw → MEM_ADDR
    - 000000 R-type → R_EXEC
    - 000100 beq / 000101 bne → BRANCH
    - 000010 j → JUMP
    - 001000 addi → ADDI_EXEC
    - Any other opcode → FETCH, with `illegal_op`=1 for this cycle only.
- DECODE latches an internal 6-bit opcode register. All later states use this latched copy.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `ALU_op`=00. Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: `mem_read`=1, `i_or_d`=1. Holds until `mem_ready`, then goes to MEM_WB.
- MEM_WB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. Goes to FETCH.
- MEM_WRITE: `mem_write`=1, `i_or_d`=1. Holds until `mem_ready`, then goes to FETCH.
- R_EXEC: `alu_src_a`=1, `alu_src_b`=00, `ALU_op`=10. Goes to R_WB.
- R_WB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. Goes to FETCH.
- BRANCH:
  - `alu_src_a`=1, `alu_src_b`=00, `ALU_op`=01, `pc_source`=01.
  - `pc_write_cond`=1 for beq; `pc_write_cond_n`=1 for bne. Exactly one of the two is high.
  - Goes to FETCH.
- JUMP: `pc_write`=1, `pc_source`=10. Goes to FETCH.
- ADDI_EXEC: `alu_src_a`=1, `alu_src_b`=10, `ALU_op`=00. Goes to ADDI_WB.
- ADDI_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Goes to FETCH.
- `pc_write`, `pc_write_cond`, `pc_write_cond_n`, `mem_write`, `reg_write` and `ir_write` are never high together in any combination except FETCH's `pc_write` + `ir_write`.

## Timing
- Reset behaviour:
  - `reset`=1 at an edge forces `state`=FETCH and clears the latched opcode.
  - While `reset` is high, all outputs are forced to 0, including `ALU_op`=00, `state`=0 and `illegal_op`=0.
  - The first FETCH cycle starts the cycle after `reset` falls.
- Reset mid-instruction (any state, including a MEM_READ/MEM_WRITE wait) aborts it; no further write strobe is issued.
- Cycle counts from FETCH entry to the next FETCH entry, with `mem_ready` tied to 1:
  - lw 5; sw 4; R-type 4; addi 4; beq/bne 3; j 3; illegal 2.
- Each cycle of `mem_ready`=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle; no strobe changes during the wait.
- `illegal_op` rises for exactly one cycle, the DECODE cycle, and never while `reset`=1.
- Opcode changes outside DECODE have no effect.

## Test plan
- Reset, then R-type (opcode 000000), `mem_ready`=1:
  - `state` sequence 0,1,6,7,0.
  - `ALU_op`=10 only in state 6.
  - `reg_write`=1 and `reg_dst`=1 only in state 7.
- lw (100011) with `mem_ready` low for 2 cycles in MEM_READ:
  - Sequence 0,1,2,3,3,3,4,0.
  - `mem_read`=1 and `i_or_d`=1 throughout state 3.
  - `mem_to_reg`=1 in state 4.
- sw (101011), then beq (000100), then bne (000101):
  - sw: sequence 0,1,2,5,0, with `mem_write` high exactly one cycle.
  - beq: `ALU_op`=01 and `pc_write_cond`=1 in state 8, `pc_write_cond_n`=0.
  - bne: `pc_write_cond_n`=1, `pc_write_cond`=0.
- FETCH with `mem_ready`=0 for 3 cycles, then opcode 000010 (j):
  - `ir_write`/`pc_write` are 0 for 3 cycles, then 1 for one cycle.
  - Then `state`=9 with `pc_write`=1 and `pc_source`=10.
- Illegal opcode 111111, and addi (001000):
  - 111111: `illegal_op`=1 for one cycle in DECODE, back to FETCH, no write strobe.
  - addi: sequence 0,1,10,11,0, with `reg_dst`=0 and `reg_write`=1 in state 11.
- Reset asserted during MEM_WRITE wait (`mem_ready`=0):
  - Next cycle `state`=0 and all outputs 0.
  - After release, a normal FETCH; `mem_write` never pulses for the aborted sw.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives the datapath strobes plus the ALU_op class code for the ALU control decoder.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic [1:0] ALU_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_write_cond_n,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    state_t     r_state;
    state_t     w_next;
    logic [5:0] r_opcode;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_FETCH;
            r_opcode <= '0;
        end else begin
            r_state <= w_next;
            // Later states must use the opcode seen in DECODE, not the live input.
            if (r_state == S_DECODE)
                r_opcode <= opcode;
        end
    end

    always_comb begin
        w_next          = S_FETCH;
        ALU_op          = 2'b00;
        alu_src_a       = 1'b0;
        alu_src_b       = 2'b00;
        pc_source       = 2'b00;
        pc_write        = 1'b0;
        pc_write_cond   = 1'b0;
        pc_write_cond_n = 1'b0;
        i_or_d          = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        ir_write        = 1'b0;
        reg_write       = 1'b0;
        reg_dst         = 1'b0;
        mem_to_reg      = 1'b0;
        illegal_op      = 1'b0;

        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                w_next    = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW:   w_next = S_MEM_ADDR;
                    OP_R:           w_next = S_R_EXEC;
                    OP_BEQ, OP_BNE: w_next = S_BRANCH;
                    OP_J:           w_next = S_JUMP;
                    OP_ADDI:        w_next = S_ADDI_EXEC;
                    default: begin
                        w_next     = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = (r_opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                w_next   = mem_ready ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                w_next    = mem_ready ? S_FETCH : S_MEM_WRITE;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                ALU_op    = 2'b10;
                w_next    = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a       = 1'b1;
                ALU_op          = 2'b01;
                pc_source       = 2'b01;
                pc_write_cond   = (r_opcode == OP_BEQ);
                pc_write_cond_n = (r_opcode != OP_BEQ);
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase

        // Reset dominates every output, including the state debug port.
        if (reset) begin
            ALU_op          = 2'b00;
            alu_src_a       = 1'b0;
            alu_src_b       = 2'b00;
            pc_source       = 2'b00;
            pc_write        = 1'b0;
            pc_write_cond   = 1'b0;
            pc_write_cond_n = 1'b0;
            i_or_d          = 1'b0;
            mem_read        = 1'b0;
            mem_write       = 1'b0;
            ir_write        = 1'b0;
            reg_write       = 1'b0;
            reg_dst         = 1'b0;
            mem_to_reg      = 1'b0;
            illegal_op      = 1'b0;
        end
        state = reset ? 4'd0 : r_state;
    end

endmodule
